// File: rtl/mux_pkg.sv
// Shared types, defaults and the round-robin search helper for mux_nto1_rr.
package mux_pkg;

    localparam int unsigned DEF_WIDTH  = 5;
    localparam int unsigned DEF_NUM_IN = 4;
    localparam int unsigned MAX_NUM_IN = 16;
    localparam int unsigned MAX_IDX_W  = 4;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Returns {found, idx}: first set bit of valid searching from ptr+1 upward, modulo n.
    function automatic logic [MAX_IDX_W:0] rr_pick(
        input logic [MAX_NUM_IN-1:0] valid,
        input logic [MAX_IDX_W-1:0]  ptr,
        input int unsigned           n
    );
        logic [MAX_IDX_W:0] res;
        int unsigned        idx;
        res = '0;
        for (int unsigned k = 1; k <= MAX_NUM_IN; k++) begin
            if (k <= n && !res[MAX_IDX_W]) begin
                idx = (32'(ptr) + k) % n;
                if (valid[MAX_IDX_W'(idx)]) begin
                    res = {1'b1, MAX_IDX_W'(idx)};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search over the valid channels plus the last-grant pointer.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int unsigned NUM_IN = DEF_NUM_IN,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IN-1:0] i_valid,
    input  logic              i_advance,
    output logic              o_found_c,
    output logic [SEL_W-1:0]  o_idx_c
);

    logic [SEL_W-1:0]     r_ptr;
    logic [MAX_IDX_W:0]   w_pick;
    logic [MAX_NUM_IN-1:0] w_valid_ext;
    logic [MAX_IDX_W-1:0] w_ptr_ext;

    assign w_valid_ext = MAX_NUM_IN'(i_valid);
    assign w_ptr_ext   = MAX_IDX_W'(r_ptr);
    assign w_pick      = rr_pick(w_valid_ext, w_ptr_ext, NUM_IN);
    assign o_found_c   = w_pick[MAX_IDX_W];
    assign o_idx_c     = SEL_W'(w_pick[MAX_IDX_W-1:0]);

    // Pointer starts at the last channel so channel 0 wins first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= SEL_W'(NUM_IN - 1);
        end else if (i_advance) begin
            r_ptr <= o_idx_c;
        end
    end

endmodule

// File: rtl/mux_nto1_rr.sv
// Registered N-to-1 valid/ready selector with explicit-select and round-robin modes.
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter  int unsigned WIDTH  = DEF_WIDTH,
    parameter  int unsigned NUM_IN = DEF_NUM_IN,
    localparam int unsigned SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    input  logic                    out_ready
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_src;
    logic               w_can_accept;
    logic               w_rr_found;
    logic [SEL_W-1:0]   w_rr_idx;
    logic               w_grant_any;
    logic [SEL_W-1:0]   w_grant_idx;
    logic [NUM_IN-1:0]  w_grant;
    logic [WIDTH-1:0]   w_grant_data;

    assign w_can_accept = (r_state == ST_EMPTY) | out_ready;

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (in_valid),
        .i_advance (mode & w_grant_any),
        .o_found_c (w_rr_found),
        .o_idx_c   (w_rr_idx)
    );

    // Grant selection; an out-of-range sel matches no channel and so never grants.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (w_can_accept) begin
            if (mode) begin
                if (w_rr_found) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = w_rr_idx;
                end
            end else begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (sel == SEL_W'(i) && in_valid[i]) begin
                        w_grant_any = 1'b1;
                        w_grant_idx = sel;
                    end
                end
            end
        end
    end

    always_comb begin
        w_grant      = '0;
        w_grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant_any && w_grant_idx == SEL_W'(i)) begin
                w_grant[i]   = 1'b1;
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = w_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_grant_any) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_grant_any) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Output register loads on every grant, including a same-cycle drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data <= '0;
            r_out_src  <= '0;
        end else if (w_grant_any) begin
            r_out_data <= w_grant_data;
            r_out_src  <= w_grant_idx;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr against a queue/arithmetic reference model.
module tb_mux_nto1_rr;

    localparam int unsigned WIDTH  = 5;
    localparam int unsigned NUM_IN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [19:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [4:0]  out_data;
    logic [1:0]  out_src;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state: output occupancy and last round-robin winner.
    int m_full;
    int m_ptr;
    int exp_q[$];   // each entry: data*16 + src

    mux_nto1_rr #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: whatever the DUT presents must match the oldest outstanding grant.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_data", int'(out_data), exp_q[0] / 16);
                check("out_src",  int'(out_src),  exp_q[0] % 16);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        m_full = 0;
        m_ptr  = NUM_IN - 1;
        exp_q.delete();
    endtask

    // One clock of stimulus; the model decides the grant from the rules alone.
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                        input logic [19:0] d, input logic ordy);
        int gnt;
        int can;
        int exp_ready;
        @(posedge clk);
        #1;
        mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        check("out_valid", int'(out_valid), m_full);
        gnt = -1;
        can = (m_full == 0 || ordy) ? 1 : 0;
        if (can != 0) begin
            if (m == 1'b0) begin
                if (int'(s) < NUM_IN && v[s]) gnt = int'(s);
            end else begin
                for (int k = 1; k <= NUM_IN; k++) begin
                    if (gnt < 0 && v[(m_ptr + k) % NUM_IN]) gnt = (m_ptr + k) % NUM_IN;
                end
            end
        end
        exp_ready = (gnt >= 0) ? (1 << gnt) : 0;
        check("in_ready", int'(in_ready), exp_ready);
        if (gnt >= 0) begin
            exp_q.push_back(int'((d >> (gnt * WIDTH)) & 20'h1F) * 16 + gnt);
            m_full = 1;
            if (m) m_ptr = gnt;
        end else if (ordy) begin
            m_full = 0;
        end
    endtask

    // Reset asserted mid-cycle while the output may be holding data.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data), 0);
        check("rst_out_src",   int'(out_src), 0);
        model_reset();
        in_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    logic [19:0] ramp;
    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        model_reset();
        ramp = {5'd6, 5'd5, 5'd4, 5'd3};
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_out_valid", int'(out_valid), 0);

        // Select mode, channel 2, then a select onto an idle channel.
        step(1'b0, 2'd2, 4'b0100, {5'd0, 5'h1A, 5'd0, 5'd0}, 1'b1);
        step(1'b0, 2'd1, 4'b0100, 20'h0, 1'b1);
        step(1'b0, 2'd0, 4'b0000, 20'h0, 1'b1);

        // Round-robin fairness with all channels requesting.
        repeat (8) step(1'b1, 2'd0, 4'b1111, ramp, 1'b1);
        step(1'b1, 2'd0, 4'b0000, ramp, 1'b1);

        // Backpressure hold then back-to-back reload.
        step(1'b0, 2'd0, 4'b0001, 20'h7, 1'b1);
        repeat (3) step(1'b0, 2'd0, 4'b0001, 20'h9, 1'b0);
        step(1'b0, 2'd1, 4'b0010, {5'd0, 5'd0, 5'h15, 5'd0}, 1'b1);
        step(1'b0, 2'd0, 4'b0000, 20'h0, 1'b1);

        // Sparse round-robin after moving the pointer to 0.
        mid_reset();
        step(1'b1, 2'd0, 4'b0001, ramp, 1'b1);
        repeat (3) step(1'b1, 2'd0, 4'b1001, ramp, 1'b1);

        // Reset during a hold, then a mode switch preserving the pointer.
        step(1'b1, 2'd0, 4'b0100, ramp, 1'b0);
        step(1'b1, 2'd0, 4'b0100, ramp, 1'b0);
        mid_reset();
        step(1'b1, 2'd0, 4'b1111, ramp, 1'b1);
        step(1'b1, 2'd0, 4'b0110, ramp, 1'b1);
        step(1'b1, 2'd0, 4'b0111, ramp, 1'b1);
        step(1'b0, 2'd1, 4'b0010, ramp, 1'b1);
        step(1'b1, 2'd0, 4'b1111, ramp, 1'b1);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom), 20'($urandom), 1'($urandom_range(0, 3) != 0));
            if (n == 200) mid_reset();
        end

        // Drain and confirm nothing is left outstanding.
        repeat (3) step(1'b0, 2'd0, 4'b0000, 20'h0, 1'b1);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
